// File: rtl/pmem_arbiter_pkg.sv
// Shared types and helpers for the physical-memory arbiter between the
// instruction and data caches.
package arb_types;

   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned LINE_WIDTH = 256;

   typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} arb_state_t;
   typedef enum logic {PORT_A, PORT_B} arb_port_t;

   // Round-robin choice between two requesters; only meaningful when one requests.
   function automatic arb_port_t rr_pick2(input logic a_req, input logic b_req,
                                          input arb_port_t last);
      if (a_req && b_req) begin
         return (last == PORT_A) ? PORT_B : PORT_A;
      end else if (a_req) begin
         return PORT_A;
      end else begin
         return PORT_B;
      end
   endfunction

endpackage

// File: rtl/pmem_arbiter.sv
// Serialises instruction- and data-cache line misses onto the single pmem port,
// one transaction at a time, with round-robin tie-breaking.
module pmem_arbiter
   import arb_types::*;
#(
   parameter int unsigned ADDR_WIDTH = arb_types::ADDR_WIDTH,
   parameter int unsigned LINE_WIDTH = arb_types::LINE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_read,
   input  logic                  a_write,
   input  logic [ADDR_WIDTH-1:0] a_address,
   input  logic [LINE_WIDTH-1:0] a_wdata,
   output logic                  a_resp,
   output logic [LINE_WIDTH-1:0] a_rdata,
   input  logic                  b_read,
   input  logic                  b_write,
   input  logic [ADDR_WIDTH-1:0] b_address,
   input  logic [LINE_WIDTH-1:0] b_wdata,
   output logic                  b_resp,
   output logic [LINE_WIDTH-1:0] b_rdata,
   input  logic                  pmem_resp,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata
);

   arb_state_t state_q, state_d;
   arb_port_t  last_q, last_d;

   logic a_req, b_req;

   assign a_req = a_read | a_write;
   assign b_req = b_read | b_write;

   // Read data is broadcast; each port qualifies it with its own resp.
   assign a_rdata = pmem_rdata;
   assign b_rdata = pmem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= PORT_B;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      a_resp       = 1'b0;
      b_resp       = 1'b0;
      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               state_d = (rr_pick2(a_req, b_req, last_q) == PORT_A) ? GRANT_A : GRANT_B;
            end
         end
         GRANT_A: begin
            // Write wins when both strobes are raised.
            pmem_read    = a_read & ~a_write;
            pmem_write   = a_write;
            pmem_address = a_address;
            pmem_wdata   = a_wdata;
            a_resp       = pmem_resp;
            if (pmem_resp) begin
               last_d  = PORT_A;
               state_d = IDLE;
            end
         end
         GRANT_B: begin
            pmem_read    = b_read & ~b_write;
            pmem_write   = b_write;
            pmem_address = b_address;
            pmem_wdata   = b_wdata;
            b_resp       = pmem_resp;
            if (pmem_resp) begin
               last_d  = PORT_B;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory line port between the two cache-side requesters below `cache_group`: port A (instruction cache) and port B (data cache).
- Serialises their line-sized read/write misses onto `pmem_*`. One transaction is outstanding at a time.
- Simultaneous requests are resolved round-robin, so neither cache can starve the other.
- Sits between the two caches' memory-side interfaces and the top-level `pmem_*` pins.

Parameters:
- `ADDR_WIDTH`, 32, width of the line address.
- `LINE_WIDTH`, 256, width of one cache line transfer.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_read`  in  1  port A line-read request.
- `a_write`  in  1  port A line-write request.
- `a_address`  in  `ADDR_WIDTH`  port A line address.
- `a_wdata`  in  `LINE_WIDTH`  port A write line.
- `a_resp`  out  1  port A transaction complete.
- `a_rdata`  out  `LINE_WIDTH`  port A read line.
- `b_read`, `b_write`, `b_address`, `b_wdata`, `b_resp`, `b_rdata`: same as the A set, for port B (data cache).
- `pmem_resp`  in  1  memory transaction complete.
- `pmem_rdata`  in  `LINE_WIDTH`  memory read line.
- `pmem_read`  out  1  memory read strobe.
- `pmem_write`  out  1  memory write strobe.
- `pmem_address`  out  `ADDR_WIDTH`  memory line address.
- `pmem_wdata`  out  `LINE_WIDTH`  memory write line.

Behaviour:
- State registers:
  - `state` ∈ {IDLE, GRANT_A, GRANT_B}.
  - `last` ∈ {A, B}, the most recently granted port.
- Reset (`rst_n` low, asynchronous):
  - `state` = IDLE, `last` = B, so A wins the first tie.
  - All outputs 0: `pmem_read`, `pmem_write`, `a_resp`, `b_resp`, `pmem_address`, `pmem_wdata`.
  - Asserting reset mid-transaction abandons it immediately. No resp is delivered to either port. The memory model is reset by the same signal.
- A port is requesting when `read | write`.
- IDLE:
  - Only A requesting: go to GRANT_A next edge.
  - Only B requesting: go to GRANT_B next edge.
  - Both requesting: grant the port ≠ `last`.
  - Neither requesting: stay in IDLE.
  - Outputs: `pmem_read`/`pmem_write` are 0 in IDLE. Arbitration costs exactly one cycle from request to strobe.
- GRANT_x (x = A or B):
  - Outputs are combinational from the granted port:
    - `pmem_read` = `x_read & ~x_write`.
    - `pmem_write` = `x_write`. Write wins if a requester illegally raises both.
    - `pmem_address` = `x_address`, `pmem_wdata` = `x_wdata`.
  - `x_resp` = `pmem_resp`. The other port's resp = 0.
  - On an edge with `pmem_resp` = 1: `last` ← x and `state` ← IDLE.
  - The grant is held until `pmem_resp`, even if the requester drops its strobe early. That is a protocol violation, and strobes follow the requester.
- `a_rdata` = `b_rdata` = `pmem_rdata` (broadcast). Validity is qualified only by the respective resp.
- Idle output values: in IDLE, `pmem_address`/`pmem_wdata` are driven to 0 (no X propagation).
- Requesters must hold strobes, address and wdata stable from assertion until their resp cycle. They must deassert on the edge after resp.
- Because of the mandatory IDLE cycle after each resp, a requester's just-dropped strobe is never re-granted.
- Latency:
  - Minimum issue latency is 1 cycle (request to `pmem_*` strobe).
  - Back-to-back transactions have a 1-cycle bubble.
  - Worst-case wait for a port is one full transaction of the other port plus 2 cycles.
- `pmem_resp` arriving in IDLE is ignored: no resp forwarded, no state change.

Decomposition:
- Shared package `arb_types`:
  - typedef enum `arb_state_t` {IDLE, GRANT_A, GRANT_B}.
  - typedef enum `arb_port_t` {PORT_A, PORT_B}.
  - `LINE_WIDTH`/`ADDR_WIDTH` default constants.
- No sub-module needed; a single FSM plus output mux.
- An optional reusable `rr_pick2` function in the package computes the tie-break from `last`.

Test Plan:
- Reset: hold `rst_n`=0 with `a_read`=1. Required: all outputs 0. Release; `pmem_read`=1 with `pmem_address`=`a_address` (0x0000_0060) exactly one cycle later.
- Single A read:
  - Stimulus: `a_read`, `a_address`=0x0000_1000. Memory responds after 5 cycles with `pmem_rdata`=256'hDEAD….
  - Required: `a_resp` for exactly that cycle, `a_rdata` matches, `b_resp`=0.
  - Next cycle `pmem_read`=0.
- Single B write:
  - Stimulus: `b_write`, `b_address`=0x0000_2040, `b_wdata`=256'h1234….
  - Required: `pmem_write`=1 with that address/data, `pmem_read`=0, and `b_resp` on `pmem_resp`.
- Simultaneous requests:
  - Stimulus: A and B raise together out of reset.
  - Required: A served first. Then one IDLE cycle, then B served with `pmem_address`=`b_address`.
  - Repeat the tie: B is now `last`-loser rule ⇒ A first again only after B was served. Check the alternation A, B, A, B over 4 contending transactions.
- Reset mid-transaction: deassert `rst_n` while in GRANT_B with `pmem_resp` pending. Required: `pmem_write`/`pmem_read` drop asynchronously, no `b_resp`, state is IDLE after release.
- Stray resp / illegal strobes:
  - `pmem_resp`=1 in IDLE: no `a_resp`/`b_resp`, no state change.
  - A asserts read and write together: `pmem_write`=1, `pmem_read`=0.
